// File: rtl/circular_ras.sv
// rtl/circular_ras.sv - circular return-address stack with one checkpoint
//
// Purpose: DEPTH-entry circular return-address stack. A push on a full stack
//   overwrites the oldest entry. A single checkpoint of {ptr, count} can be
//   saved and restored. Entries are never recovered on restore.
//
// Ports:
//   clk_i, rst_i     clock; asynchronous active-high reset
//   flush_i          clear pointer, count and checkpoint
//   push_i, push_addr_i   call: push return address
//   pop_i            return: pop top entry
//   ckpt_save_i      snapshot {ptr, count}
//   ckpt_restore_i   reload {ptr, count} from snapshot
//   top_o, top_valid_o, count_o   combinational view of registered state
//   overflow_o       push on full stack overwrote the oldest entry this cycle
//   underflow_o      pop on empty stack this cycle
module circular_ras #(
  parameter int unsigned VLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [VLEN-1:0]            push_addr_i,
  input  logic                       pop_i,
  input  logic                       ckpt_save_i,
  input  logic                       ckpt_restore_i,
  output logic [VLEN-1:0]            top_o,
  output logic                       top_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [VLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ckpt_ptr_q, ckpt_ptr_d;
  logic [CW-1:0]   ckpt_cnt_q, ckpt_cnt_d;
  logic            overflow, underflow;
  logic [PW-1:0]   ptr_inc, ptr_dec;

  // DEPTH is a power of two, so the pointer wraps by natural overflow.
  assign ptr_inc = ptr_q + PW'(1);
  assign ptr_dec = ptr_q - PW'(1);

  always_comb begin
    mem_d      = mem_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ckpt_ptr_d = ckpt_ptr_q;
    ckpt_cnt_d = ckpt_cnt_q;
    overflow   = 1'b0;
    underflow  = 1'b0;
    if (flush_i) begin
      ptr_d      = '0;
      cnt_d      = '0;
      ckpt_ptr_d = '0;
      ckpt_cnt_d = '0;
    end else if (ckpt_restore_i) begin
      ptr_d = ckpt_ptr_q;
      cnt_d = ckpt_cnt_q;
    end else begin
      if (ckpt_save_i) begin
        ckpt_ptr_d = ptr_q;
        ckpt_cnt_d = cnt_q;
      end
      if (push_i && pop_i && cnt_q != '0) begin
        // Call and return together: replace the top entry in place.
        mem_d[ptr_q] = push_addr_i;
      end else if (push_i) begin
        // Also covers push+pop on empty, which behaves as a plain push.
        ptr_d          = ptr_inc;
        mem_d[ptr_inc] = push_addr_i;
        if (cnt_q == FULL) begin
          overflow = ~pop_i;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (pop_i) begin
        if (cnt_q == '0) begin
          underflow = 1'b1;
        end else begin
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      ptr_q      <= '0;
      cnt_q      <= '0;
      ckpt_ptr_q <= '0;
      ckpt_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ckpt_ptr_q <= ckpt_ptr_d;
      ckpt_cnt_q <= ckpt_cnt_d;
    end
  end

  assign top_o       = (cnt_q != '0) ? mem_q[ptr_q] : '0;
  assign top_valid_o = (cnt_q != '0);
  assign count_o     = cnt_q;
  // Reset is asynchronous, so the flags are masked directly by rst_i.
  assign overflow_o  = overflow & ~rst_i;
  assign underflow_o = underflow & ~rst_i;

endmodule

// File: tb/tb_circular_ras.sv
// tb/tb_circular_ras.sv - self-checking bench for circular_ras (DEPTH 2 and 4)
module tb_circular_ras;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, push, pop, save, restore;
  logic [63:0] addr;

  logic [63:0] top2, top4;
  logic        val2, val4, ov2, ov4, un2, un4;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;

  circular_ras #(.VLEN(64), .DEPTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .push_addr_i(addr),
    .pop_i(pop), .ckpt_save_i(save), .ckpt_restore_i(restore),
    .top_o(top2), .top_valid_o(val2), .count_o(cnt2),
    .overflow_o(ov2), .underflow_o(un2)
  );

  circular_ras #(.VLEN(64), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .push_addr_i(addr),
    .pop_i(pop), .ckpt_save_i(save), .ckpt_restore_i(restore),
    .top_o(top4), .top_valid_o(val4), .count_o(cnt4),
    .overflow_o(ov4), .underflow_o(un4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 is the DEPTH=2 stack, index 1 the DEPTH=4 stack.
  logic [63:0] mm [2][4];
  int mp [2];
  int mc [2];
  int kp [2];
  int kc [2];
  int dep [2] = '{2, 4};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_top(input int k);
    return (mc[k] != 0) ? mm[k][mp[k]] : 64'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) mm[k][i] = 64'd0;
      mp[k] = 0; mc[k] = 0; kp[k] = 0; kc[k] = 0;
    end
  endtask

  task automatic model_update(input bit pu, input bit po, input logic [63:0] a,
                              input bit sv, input bit rs, input bit fl);
    for (int k = 0; k < 2; k++) begin
      int d;
      d = dep[k];
      if (fl) begin
        mp[k] = 0; mc[k] = 0; kp[k] = 0; kc[k] = 0;
      end else if (rs) begin
        mp[k] = kp[k]; mc[k] = kc[k];
      end else begin
        if (sv) begin
          kp[k] = mp[k]; kc[k] = mc[k];
        end
        if (pu && po && mc[k] > 0) begin
          mm[k][mp[k]] = a;
        end else if (pu) begin
          mp[k] = (mp[k] + 1) % d;
          mm[k][mp[k]] = a;
          if (mc[k] < d) mc[k] = mc[k] + 1;
        end else if (po && mc[k] > 0) begin
          mp[k] = (mp[k] - 1 + d) % d;
          mc[k] = mc[k] - 1;
        end
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "/top2"}, top2, exp_top(0));
    chk({tag, "/val2"}, {63'd0, val2}, {63'd0, mc[0] != 0});
    chk({tag, "/cnt2"}, {62'd0, cnt2}, 64'(mc[0]));
    chk({tag, "/top4"}, top4, exp_top(1));
    chk({tag, "/val4"}, {63'd0, val4}, {63'd0, mc[1] != 0});
    chk({tag, "/cnt4"}, {61'd0, cnt4}, 64'(mc[1]));
  endtask

  // Called at a negedge: drive, check flags before the edge, clock, check state.
  task automatic step(input string tag, input bit pu, input bit po, input logic [63:0] a,
                      input bit sv, input bit rs, input bit fl);
    push = pu; pop = po; addr = a; save = sv; restore = rs; flush = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit eo, eu;
      eo = !fl && !rs && pu && !po && (mc[k] == dep[k]);
      eu = !fl && !rs && po && !pu && (mc[k] == 0);
      chk({tag, (k == 0) ? "/ov2" : "/ov4"}, {63'd0, (k == 0) ? ov2 : ov4}, {63'd0, eo});
      chk({tag, (k == 0) ? "/un2" : "/un4"}, {63'd0, (k == 0) ? un2 : un4}, {63'd0, eu});
    end
    @(posedge clk);
    model_update(pu, po, a, sv, rs, fl);
    #1;
    check_outs(tag);
    @(negedge clk);
    push = 0; pop = 0; save = 0; restore = 0; flush = 0; addr = 64'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "/top2"}, top2, 64'd0);
    chk({tag, "/top4"}, top4, 64'd0);
    chk({tag, "/flags"}, {56'd0, val2, val4, ov2, ov4, un2, un4, 2'b00}, 64'd0);
    chk({tag, "/cnt"}, {59'd0, cnt2, cnt4}, 64'd0);
  endtask

  initial begin
    rst = 1; flush = 0; push = 0; pop = 0; save = 0; restore = 0; addr = 64'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    // Basic push/pop
    step("p10", 1, 0, 64'h8000_0010, 0, 0, 0);
    step("p20", 1, 0, 64'h8000_0020, 0, 0, 0);
    chk("c032_top", top2, 64'h8000_0020);
    chk("c032_cnt", {62'd0, cnt2}, 64'd2);
    step("pop", 0, 1, 64'd0, 0, 0, 0);
    chk("c032_pop", top2, 64'h8000_0010);

    // Overflow / underflow on DEPTH=2
    step("fl", 0, 0, 64'd0, 0, 0, 1);
    step("A", 1, 0, 64'h10, 0, 0, 0);
    step("B", 1, 0, 64'h20, 0, 0, 0);
    push = 1; addr = 64'h30; #1;
    chk("c033_ov_C", {63'd0, ov2}, 64'd1);
    push = 0; addr = 64'd0;
    step("C", 1, 0, 64'h30, 0, 0, 0);
    chk("c033_top", top2, 64'h30);
    step("pop1", 0, 1, 64'd0, 0, 0, 0);
    chk("c033_pop1", top2, 64'h20);
    step("pop2", 0, 1, 64'd0, 0, 0, 0);
    pop = 1; #1;
    chk("c033_un", {63'd0, un2}, 64'd1);
    pop = 0;
    step("pop3", 0, 1, 64'd0, 0, 0, 0);

    // Push+pop replace and on empty
    step("fl", 0, 0, 64'd0, 0, 0, 1);
    step("p10", 1, 0, 64'h10, 0, 0, 0);
    step("pp44", 1, 1, 64'h44, 0, 0, 0);
    chk("c034_top", top2, 64'h44);
    step("fl", 0, 0, 64'd0, 0, 0, 1);
    step("pp55", 1, 1, 64'h55, 0, 0, 0);
    chk("c034_empty", {top2[55:0], 6'd0, cnt2}, {56'h55, 6'd0, 2'd1});

    // Checkpoint
    step("fl", 0, 0, 64'd0, 0, 0, 1);
    step("p10", 1, 0, 64'h10, 0, 0, 0);
    step("save", 0, 0, 64'd0, 1, 0, 0);
    step("p20", 1, 0, 64'h20, 0, 0, 0);
    step("pop", 0, 1, 64'd0, 0, 0, 0);
    step("pop", 0, 1, 64'd0, 0, 0, 0);
    step("rest", 0, 0, 64'd0, 0, 1, 0);
    chk("c035_rest", {top2[55:0], 6'd0, cnt2}, {56'h10, 6'd0, 2'd1});
    step("p20", 1, 0, 64'h20, 0, 0, 0);
    step("svrs", 1, 1, 64'h99, 1, 1, 0);
    step("p77", 1, 0, 64'h77, 0, 0, 0);
    step("rest2", 0, 0, 64'd0, 0, 1, 0);
    chk("c035_keep", {62'd0, cnt2}, 64'd1);

    // DEPTH=4 wrap
    step("fl", 0, 0, 64'd0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) step("wrap", 1, 0, 64'(i), 0, 0, 0);
    chk("c036_top", top4, 64'h5);
    for (int i = 0; i < 4; i++) step("wpop", 0, 1, 64'd0, 0, 0, 0);
    chk("c036_cnt", {61'd0, cnt4}, 64'd0);

    // Flush with push, then restore
    step("p9", 1, 0, 64'h9, 0, 0, 0);
    step("save", 0, 0, 64'd0, 1, 0, 0);
    step("flp", 1, 0, 64'hAB, 0, 0, 1);
    step("rest", 0, 0, 64'd0, 0, 1, 0);
    chk("c037_cnt", {61'd0, cnt4}, 64'd0);

    // Asynchronous reset between edges
    step("p1", 1, 0, 64'hA1, 0, 0, 0);
    step("p2", 1, 0, 64'hA2, 0, 0, 0);
    #2;
    pop = 1; push = 0;
    rst = 1;
    #1;
    check_all_zero("async_rst");
    pop = 0; push = 1; addr = 64'hEE;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst = 0; push = 0; addr = 64'd0;
    step("after_rst", 1, 0, 64'hB0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit pu, po, sv, rs, fl;
      logic [63:0] a;
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      sv = ($urandom_range(0, 99) < 12);
      rs = ($urandom_range(0, 99) < 8);
      fl = ($urandom_range(0, 99) < 3);
      a  = {$urandom, $urandom};
      step("rand", pu, po, a, sv, rs, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
